// File: rtl/div_result_bcd.sv
// div_result_bcd: converts a divider's 6-bit quotient and 4-bit remainder
// into two-digit BCD values with a serial double-dabble engine. One shift
// step runs per clock, so a conversion takes six clocks from the start edge.
//
// Optional feature: define BCD_SEG7_EN to add four registered, active-low
// seven-segment outputs (seg_q1, seg_q0, seg_r1, seg_r0), ordered {g,f,e,d,c,b,a}.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a rising edge of done; outputs hold the last result
// CONV  | one double-dabble step per clock until the counter reaches zero
module div_result_bcd (
    input  logic       clk,
    input  logic       reset,
    input  logic       done,
    input  logic [5:0] Q,
    input  logic [3:0] R,
`ifdef BCD_SEG7_EN
    output logic [6:0] seg_q1,
    output logic [6:0] seg_q0,
    output logic [6:0] seg_r1,
    output logic [6:0] seg_r0,
`endif
    output logic [7:0] q_bcd,
    output logic [7:0] r_bcd,
    output logic       busy,
    output logic       valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [2:0] NUM_STEPS = 3'd6;

    logic [0:0] state_q, state_d;
    logic       done_q, done_d;
    logic [5:0] qbin_q, qbin_d;
    logic [5:0] rbin_q, rbin_d;
    logic [7:0] qscr_q, qscr_d;
    logic [7:0] rscr_q, rscr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] q_bcd_q, q_bcd_d;
    logic [7:0] r_bcd_q, r_bcd_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;

    logic       start;
    logic [7:0] qscr_adj, rscr_adj;
    logic [7:0] qscr_nxt, rscr_nxt;
    logic [5:0] qbin_nxt, rbin_nxt;

    // Add 3 to any BCD digit of 5 or more so the following shift carries
    // correctly into the next decimal place.
    function automatic logic [3:0] digit_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    function automatic logic [7:0] scratch_adj(input logic [7:0] s);
        return {digit_adj(s[7:4]), digit_adj(s[3:0])};
    endfunction

    // Rising edge of done while idle starts a conversion; edges seen during
    // CONV are dropped rather than queued.
    always_comb begin
        start = done && !done_q && (state_q == IDLE);
    end

    // One double-dabble step on both operands: adjust, then shift
    // {scratch, binary} left by one.
    always_comb begin
        qscr_adj = scratch_adj(qscr_q);
        rscr_adj = scratch_adj(rscr_q);
        qscr_nxt = {qscr_adj[6:0], qbin_q[5]};
        rscr_nxt = {rscr_adj[6:0], rbin_q[5]};
        qbin_nxt = {qbin_q[4:0], 1'b0};
        rbin_nxt = {rbin_q[4:0], 1'b0};
    end

    // Next-state logic for the sequencer, datapath and result registers.
    always_comb begin
        state_d = state_q;
        done_d  = done;
        qbin_d  = qbin_q;
        rbin_d  = rbin_q;
        qscr_d  = qscr_q;
        rscr_d  = rscr_q;
        cnt_d   = cnt_q;
        q_bcd_d = q_bcd_q;
        r_bcd_d = r_bcd_q;
        busy_d  = busy_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    qbin_d  = Q;
                    rbin_d  = {2'b00, R};
                    qscr_d  = 8'h00;
                    rscr_d  = 8'h00;
                    cnt_d   = NUM_STEPS;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            CONV: begin
                qscr_d = qscr_nxt;
                rscr_d = rscr_nxt;
                qbin_d = qbin_nxt;
                rbin_d = rbin_nxt;
                cnt_d  = cnt_q - 3'd1;
                // The last step publishes the freshly shifted scratch values,
                // so the result registers only ever change on this edge.
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    q_bcd_d = qscr_nxt;
                    r_bcd_d = rscr_nxt;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            qbin_q  <= 6'd0;
            rbin_q  <= 6'd0;
            qscr_q  <= 8'h00;
            rscr_q  <= 8'h00;
            cnt_q   <= 3'd0;
            q_bcd_q <= 8'h00;
            r_bcd_q <= 8'h00;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            qbin_q  <= qbin_d;
            rbin_q  <= rbin_d;
            qscr_q  <= qscr_d;
            rscr_q  <= rscr_d;
            cnt_q   <= cnt_d;
            q_bcd_q <= q_bcd_d;
            r_bcd_q <= r_bcd_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign q_bcd = q_bcd_q;
    assign r_bcd = r_bcd_q;
    assign busy  = busy_q;
    assign valid = valid_q;

`ifdef BCD_SEG7_EN
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    logic [6:0] seg_q1_q, seg_q1_d;
    logic [6:0] seg_q0_q, seg_q0_d;
    logic [6:0] seg_r1_q, seg_r1_d;
    logic [6:0] seg_r0_q, seg_r0_d;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Decode the next result values so the segments change on the same
    // edge as q_bcd and r_bcd.
    always_comb begin
        seg_q1_d = seg7(q_bcd_d[7:4]);
        seg_q0_d = seg7(q_bcd_d[3:0]);
        seg_r1_d = seg7(r_bcd_d[7:4]);
        seg_r0_d = seg7(r_bcd_d[3:0]);
    end

    // Segment output registers; reset shows digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q1_q <= SEG_ZERO;
            seg_q0_q <= SEG_ZERO;
            seg_r1_q <= SEG_ZERO;
            seg_r0_q <= SEG_ZERO;
        end else begin
            seg_q1_q <= seg_q1_d;
            seg_q0_q <= seg_q0_d;
            seg_r1_q <= seg_r1_d;
            seg_r0_q <= seg_r0_d;
        end
    end

    assign seg_q1 = seg_q1_q;
    assign seg_q0 = seg_q0_q;
    assign seg_r1 = seg_r1_q;
    assign seg_r0 = seg_r0_q;
`endif

endmodule

// File: tb/tb_div_result_bcd.sv
// Testbench for div_result_bcd: directed scenarios plus randomized
// conversions checked against a decimal-arithmetic reference.
module tb_div_result_bcd;

    logic       clk;
    logic       reset;
    logic       done;
    logic [5:0] Q;
    logic [3:0] R;
    logic [7:0] q_bcd;
    logic [7:0] r_bcd;
    logic       busy;
    logic       valid;
`ifdef BCD_SEG7_EN
    logic [6:0] seg_q1, seg_q0, seg_r1, seg_r0;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_q;
    logic [7:0] exp_r;

    div_result_bcd dut (
        .clk   (clk),
        .reset (reset),
        .done  (done),
        .Q     (Q),
        .R     (R),
`ifdef BCD_SEG7_EN
        .seg_q1(seg_q1),
        .seg_q0(seg_q0),
        .seg_r1(seg_r1),
        .seg_r0(seg_r0),
`endif
        .q_bcd (q_bcd),
        .r_bcd (r_bcd),
        .busy  (busy),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: two decimal digits packed as nibbles.
    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

`ifdef BCD_SEG7_EN
    function automatic logic [6:0] seg_ref(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction
`endif

    task automatic chk_result(input string tag, input int qv, input int rv);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_q"}, 32'(q_bcd), 32'(to_bcd(qv)));
        chk({tag, "_r"}, 32'(r_bcd), 32'(to_bcd(rv)));
`ifdef BCD_SEG7_EN
        chk({tag, "_sq1"}, 32'(seg_q1), 32'(seg_ref(qv / 10)));
        chk({tag, "_sq0"}, 32'(seg_q0), 32'(seg_ref(qv % 10)));
        chk({tag, "_sr1"}, 32'(seg_r1), 32'(seg_ref(rv / 10)));
        chk({tag, "_sr0"}, 32'(seg_r0), 32'(seg_ref(rv % 10)));
`endif
    endtask

    // One-cycle done pulse with operands; while busy, the previous result
    // must hold and the inputs are scrambled. glitch_at>0 raises done again
    // at that busy cycle with Q=17 to show mid-conversion edges are ignored.
    task automatic run_conv(input int qv, input int rv, input int glitch_at, output int nbusy);
        Q = 6'(qv);
        R = 4'(rv);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 20) begin
            chk("hold_q", 32'(q_bcd), 32'(exp_q));
            chk("hold_r", 32'(r_bcd), 32'(exp_r));
            chk("valid_low", 32'(valid), 32'd0);
            nbusy++;
            Q = 6'($urandom_range(63));
            R = 4'($urandom_range(15));
            if (glitch_at > 0 && nbusy == glitch_at) begin
                done = 1'b1;
                Q = 6'd17;
            end
            if (glitch_at > 0 && nbusy == glitch_at + 1) done = 1'b0;
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    initial begin
        int nb;
        int qv, rv;

        reset = 1'b1;
        done  = 1'b0;
        Q     = '0;
        R     = '0;
        exp_q = 8'h00;
        exp_r = 8'h00;

        // Reset with done high: reset must win.
        repeat (2) @(negedge clk);
        done = 1'b1;
        Q = 6'd33;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_q", 32'(q_bcd), 32'h00);
        chk("rst_r", 32'(r_bcd), 32'h00);
`ifdef BCD_SEG7_EN
        chk("rst_seg", 32'({seg_q1, seg_q0, seg_r1, seg_r0}), 32'({4{7'b1000000}}));
`endif
        reset = 1'b0;
        done  = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Largest operands.
        run_conv(63, 15, 0, nb);
        chk("max_lat", 32'(nb), 32'd6);
        chk_result("max", 63, 15);
        exp_q = 8'h63; exp_r = 8'h15;

        // Zeros.
        run_conv(0, 0, 0, nb);
        chk("zero_lat", 32'(nb), 32'd6);
        chk_result("zero", 0, 0);
        exp_q = 8'h00; exp_r = 8'h00;

        // Ignored done edge mid-conversion.
        run_conv(40, 9, 3, nb);
        chk("glitch_lat", 32'(nb), 32'd6);
        chk_result("glitch", 40, 9);
        exp_q = 8'h40; exp_r = 8'h09;
        repeat (4) begin
            @(negedge clk);
            chk("no_restart_busy", 32'(busy), 32'd0);
            chk("valid_hold", 32'(valid), 32'd1);
        end
        run_conv(17, 3, 0, nb);
        chk("second_lat", 32'(nb), 32'd6);
        chk_result("second", 17, 3);
        exp_q = 8'h17; exp_r = 8'h03;

        // Reset in mid-conversion.
        Q = 6'd55; R = 4'd12; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_q", 32'(q_bcd), 32'h00);
        chk("midrst_r", 32'(r_bcd), 32'h00);
        repeat (8) @(negedge clk);
        chk("midrst_no_result", 32'(valid), 32'd0);
        exp_q = 8'h00; exp_r = 8'h00;
        run_conv(55, 12, 0, nb);
        chk("after_rst_lat", 32'(nb), 32'd6);
        chk_result("after_rst", 55, 12);
        exp_q = to_bcd(55); exp_r = to_bcd(12);

        // done held high: exactly one conversion.
        Q = 6'd25; R = 4'd7; done = 1'b1;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        done = 1'b0;
        @(negedge clk);
        chk("held_busy_cycles", 32'(nb), 32'd6);
        chk_result("held", 25, 7);
        exp_q = 8'h25; exp_r = 8'h07;

`ifdef BCD_SEG7_EN
        run_conv(36, 10, 0, nb);
        chk("seg_q1_36", 32'(seg_q1), 32'(7'b0110000));
        chk("seg_q0_36", 32'(seg_q0), 32'(7'b0000010));
        chk("seg_r1_10", 32'(seg_r1), 32'(7'b1111001));
        chk("seg_r0_10", 32'(seg_r0), 32'(7'b1000000));
        exp_q = to_bcd(36); exp_r = to_bcd(10);
`endif

        // Randomized conversions with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            qv = int'($urandom_range(63));
            rv = int'($urandom_range(15));
            run_conv(qv, rv, (k % 4 == 0) ? int'($urandom_range(1, 4)) : 0, nb);
            chk("rand_lat", 32'(nb), 32'd6);
            chk_result("rand", qv, rv);
            exp_q = to_bcd(qv);
            exp_r = to_bcd(rv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rand_idle_valid", 32'(valid), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
